// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: queue entry layout and ISA mode encodings.
package fetch_pkg;

   localparam int unsigned INST_W = 48;

   localparam logic MODE_MIPS = 1'b0;
   localparam logic MODE_VAR  = 1'b1;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [31:0]       pc;
      logic [31:0]       next_pc;
      logic              mode;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; head is read combinationally from storage.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_en, push_en;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop_en   = pop & (count_q != '0);
      // A push into a full FIFO is only accepted when the head leaves in the same cycle.
      push_en  = push & ((count_q != CW'(DEPTH)) | pop_en);
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push_en) - CW'(pop_en);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Sequential half of the fetch stage: fetch state registers, byte address, redirect and
// back-pressure handling, and the instruction queue toward decode.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic        RESET_MODE = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic [31:0]              imem_addr,
   output logic [31:0]              f_pc,
   output logic [2:0]               f_off,
   output logic [INST_W-1:0]        f_inst,
   output logic                     f_mode,
   input  logic [2:0]               cu_next_off,
   input  logic [31:0]              cu_next_pc,
   input  logic [INST_W-1:0]        cu_inst,
   input  logic                     cu_next_mode,
   input  logic [31:0]              cu_next_inst_pc,
   input  logic                     d_flush_fetch,
   input  logic [31:0]              d_target_pc,
   input  logic                     d_target_mode,
   output logic                     q_valid,
   input  logic                     q_ready,
   output logic [INST_W-1:0]        q_inst,
   output logic [31:0]              q_pc,
   output logic [31:0]              q_next_pc,
   output logic                     q_mode,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [31:0]       f_pc_q, f_pc_d;
   logic [2:0]        f_off_q, f_off_d;
   logic [INST_W-1:0] f_inst_q, f_inst_d;
   logic              f_mode_q, f_mode_d;

   logic         done, pop, full, stall;
   logic         fifo_push, fifo_pop, fifo_clr;
   fetch_entry_t push_entry, head;
   logic [CW-1:0] count;

   always_comb begin
      done  = (cu_next_off == 3'd0);
      pop   = q_valid & q_ready;
      full  = (count == CW'(DEPTH));
      stall = done & full & ~pop;

      f_pc_d    = f_pc_q;
      f_off_d   = f_off_q;
      f_inst_d  = f_inst_q;
      f_mode_d  = f_mode_q;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      fifo_clr  = 1'b0;

      push_entry.inst    = cu_inst;
      push_entry.pc      = f_pc_q;
      push_entry.next_pc = cu_next_inst_pc;
      push_entry.mode    = f_mode_q;

      if (d_flush_fetch) begin
         f_pc_d   = d_target_pc;
         f_off_d  = 3'd0;
         f_inst_d = '0;
         f_mode_d = d_target_mode;
         fifo_clr = 1'b1;
      end else if (!stall) begin
         f_pc_d    = cu_next_pc;
         f_off_d   = cu_next_off;
         f_mode_d  = cu_next_mode;
         f_inst_d  = done ? '0 : cu_inst;
         fifo_push = done;
         fifo_pop  = pop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_pc_q   <= RESET_PC;
         f_off_q  <= 3'd0;
         f_inst_q <= '0;
         f_mode_q <= RESET_MODE;
      end else begin
         f_pc_q   <= f_pc_d;
         f_off_q  <= f_off_d;
         f_inst_q <= f_inst_d;
         f_mode_q <= f_mode_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (fifo_clr),
      .push       (fifo_push),
      .push_entry (push_entry),
      .pop        (fifo_pop),
      .count      (count),
      .head       (head)
   );

   assign imem_addr = f_pc_q + {29'd0, f_off_q};
   assign f_pc      = f_pc_q;
   assign f_off     = f_off_q;
   assign f_inst    = f_inst_q;
   assign f_mode    = f_mode_q;
   assign q_count   = count;
   assign q_valid   = (count != '0);
   assign q_inst    = head.inst;
   assign q_pc      = head.pc;
   assign q_next_pc = head.next_pc;
   assign q_mode    = head.mode;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue with a behavioural fetch_cu and queue model.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk, rst_n;
   logic [31:0] imem_addr, f_pc;
   logic [2:0]  f_off;
   logic [47:0] f_inst;
   logic        f_mode;
   logic [2:0]  cu_next_off;
   logic [31:0] cu_next_pc, cu_next_inst_pc;
   logic [47:0] cu_inst;
   logic        cu_next_mode;
   logic        d_flush_fetch, d_target_mode;
   logic [31:0] d_target_pc;
   logic        q_valid, q_ready, q_mode;
   logic [47:0] q_inst;
   logic [31:0] q_pc, q_next_pc;
   logic [2:0]  q_count;

   fetch_queue #(
      .DEPTH      (DEPTH),
      .RESET_PC   (32'h0),
      .RESET_MODE (1'b0)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .f_pc            (f_pc),
      .f_off           (f_off),
      .f_inst          (f_inst),
      .f_mode          (f_mode),
      .cu_next_off     (cu_next_off),
      .cu_next_pc      (cu_next_pc),
      .cu_inst         (cu_inst),
      .cu_next_mode    (cu_next_mode),
      .cu_next_inst_pc (cu_next_inst_pc),
      .d_flush_fetch   (d_flush_fetch),
      .d_target_pc     (d_target_pc),
      .d_target_mode   (d_target_mode),
      .q_valid         (q_valid),
      .q_ready         (q_ready),
      .q_inst          (q_inst),
      .q_pc            (q_pc),
      .q_next_pc       (q_next_pc),
      .q_mode          (q_mode),
      .q_count         (q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [4096];

   // Variable-length encoding: low 3 bits of the first byte give the length, 0 and 7 mean 1.
   function automatic int vlen(input logic [7:0] b);
      int l;
      l = int'(b[2:0]);
      if (l == 0 || l == 7) return 1;
      return l;
   endfunction

   // Behavioural fetch_cu: little-endian byte assembly, mode 0 is fixed 4 bytes.
   logic [7:0] cu_byte, cu_first;
   int         cu_len;
   always_comb begin
      cu_byte         = mem[imem_addr[11:0]];
      cu_first        = (f_off == 3'd0) ? cu_byte : f_inst[7:0];
      cu_len          = f_mode ? vlen(cu_first) : 4;
      cu_inst         = f_inst | (48'(cu_byte) << (8 * int'(f_off)));
      cu_next_mode    = f_mode;
      cu_next_inst_pc = f_pc + 32'(cu_len);
      if (int'(f_off) + 1 == cu_len) begin
         cu_next_off = 3'd0;
         cu_next_pc  = f_pc + 32'(cu_len);
      end else begin
         cu_next_off = f_off + 3'd1;
         cu_next_pc  = f_pc;
      end
   end

   typedef struct {
      logic [47:0] inst;
      logic [31:0] pc;
      logic [31:0] npc;
      logic        mode;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   int          m_off;
   logic [47:0] m_inst;
   logic        m_mode;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = 32'h0;
      m_off  = 0;
      m_inst = '0;
      m_mode = 1'b0;
      mq.delete();
   endtask

   task automatic check_all();
      chk("imem_addr", 64'(imem_addr), 64'(m_pc + 32'(m_off)));
      chk("f_pc", 64'(f_pc), 64'(m_pc));
      chk("f_off", 64'(f_off), 64'(m_off));
      chk("f_inst", 64'(f_inst), 64'(m_inst));
      chk("f_mode", 64'(f_mode), 64'(m_mode));
      chk("q_valid", 64'(q_valid), 64'(mq.size() > 0));
      chk("q_count", 64'(q_count), 64'(mq.size()));
      if (mq.size() > 0) begin
         chk("q_inst", 64'(q_inst), 64'(mq[0].inst));
         chk("q_pc", 64'(q_pc), 64'(mq[0].pc));
         chk("q_next_pc", 64'(q_next_pc), 64'(mq[0].npc));
         chk("q_mode", 64'(q_mode), 64'(mq[0].mode));
      end
   endtask

   // One clock: drive inputs, check against the model, advance the model, take the edge.
   task automatic step(input bit rdy, input bit fl, input logic [31:0] tpc, input bit tm);
      logic [7:0]  b, first;
      int          len;
      bit          done, pop;
      logic [47:0] inst;
      ent_t        e;
      q_ready       = rdy;
      d_flush_fetch = fl;
      d_target_pc   = tpc;
      d_target_mode = tm;
      #1;
      check_all();
      if (fl) begin
         m_pc   = tpc;
         m_off  = 0;
         m_inst = '0;
         m_mode = tm;
         mq.delete();
      end else begin
         b     = mem[12'(m_pc + 32'(m_off))];
         first = (m_off == 0) ? b : m_inst[7:0];
         len   = m_mode ? vlen(first) : 4;
         done  = (m_off + 1 == len);
         pop   = rdy && (mq.size() > 0);
         if (!(done && mq.size() == DEPTH && !pop)) begin
            inst = m_inst | (48'(b) << (8 * m_off));
            if (pop) void'(mq.pop_front());
            if (done) begin
               e.inst = inst;
               e.pc   = m_pc;
               e.npc  = m_pc + 32'(len);
               e.mode = m_mode;
               mq.push_back(e);
               m_pc   = m_pc + 32'(len);
               m_off  = 0;
               m_inst = '0;
            end else begin
               m_off  = m_off + 1;
               m_inst = inst;
            end
         end
      end
      @(posedge clk);
      #1;
      d_flush_fetch = 1'b0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      chk({pfx, "_imem_addr"}, 64'(imem_addr), 64'h0);
      chk({pfx, "_f_pc"}, 64'(f_pc), 64'h0);
      chk({pfx, "_f_off"}, 64'(f_off), 64'h0);
      chk({pfx, "_f_inst"}, 64'(f_inst), 64'h0);
      chk({pfx, "_f_mode"}, 64'(f_mode), 64'h0);
      chk({pfx, "_q_valid"}, 64'(q_valid), 64'h0);
      chk({pfx, "_q_count"}, 64'(q_count), 64'h0);
      chk({pfx, "_q_inst"}, 64'(q_inst), 64'h0);
      chk({pfx, "_q_pc"}, 64'(q_pc), 64'h0);
      chk({pfx, "_q_next_pc"}, 64'(q_next_pc), 64'h0);
      chk({pfx, "_q_mode"}, 64'(q_mode), 64'h0);
   endtask

   initial begin
      rst_n         = 1'b0;
      q_ready       = 1'b0;
      d_flush_fetch = 1'b0;
      d_target_pc   = '0;
      d_target_mode = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      mem[12'h010] = 8'h02;
      mem[12'h011] = 8'hAB;
      mem[12'h200] = 8'h06;
      mem[12'h400] = 8'h01;
      mem[12'h401] = 8'h01;
      mem[12'h402] = 8'h04;
      model_reset();

      // Reset values while held, then release.
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      step(0, 0, 0, 0);

      // Two-byte variable-length instruction at 0x10.
      step(0, 1, 32'h10, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t2_q_valid", 64'(q_valid), 64'h1);
      chk("t2_q_inst", 64'(q_inst), 64'h0000_0000_AB02);
      chk("t2_q_pc", 64'(q_pc), 64'h10);
      chk("t2_q_next_pc", 64'(q_next_pc), 64'h12);

      // One-byte stream fills the queue and stalls fetch, then drains at one per cycle.
      step(0, 1, 32'h0, 1);
      repeat (6) step(0, 0, 0, 0);
      chk("t3_full_count", 64'(q_count), 64'h4);
      chk("t3_frozen_pc", 64'(f_pc), 64'h4);
      step(1, 0, 0, 0);
      chk("t4_count_full", 64'(q_count), 64'h4);
      chk("t4_head_pc", 64'(q_pc), 64'h1);
      chk("t4_fetch_resumed", 64'(f_pc), 64'h5);
      repeat (6) step(1, 0, 0, 0);

      // Redirect in the middle of a six-byte instruction.
      step(0, 1, 32'h200, 1);
      repeat (3) step(0, 0, 0, 0);
      chk("t5_mid_off", 64'(f_off), 64'h3);
      step(0, 1, 32'h100, 0);
      chk("t5_f_pc", 64'(f_pc), 64'h100);
      chk("t5_f_off", 64'(f_off), 64'h0);
      chk("t5_f_inst", 64'(f_inst), 64'h0);
      chk("t5_f_mode", 64'(f_mode), 64'h0);
      chk("t5_q_count", 64'(q_count), 64'h0);
      repeat (10) step(1'($urandom_range(0, 1)), 0, 0, 0);

      // Asynchronous reset mid-instruction with two entries queued.
      step(0, 1, 32'h400, 1);
      repeat (3) step(0, 0, 0, 0);
      chk("t6_count", 64'(q_count), 64'h2);
      chk("t6_off", 64'(f_off), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6");
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized traffic with occasional redirects and back-pressure bursts.
      for (int i = 0; i < 400; i++) begin
         bit rdy, fl;
         rdy = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 24) == 0);
         step(rdy, fl, 32'($urandom_range(0, 4000)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
